// File: rtl/wb_write_queue.sv
// Register file writeback queue: arbitrates mem/alu/mdu results into a FIFO,
// drains one entry per cycle and forwards queued operands to decode.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_valid,
  input  logic [AW-1:0]            mem_reg,
  input  logic [DW-1:0]            mem_data,
  input  logic                     mem_float,
  output logic                     mem_ready,
  input  logic                     alu_valid,
  input  logic [AW-1:0]            alu_reg,
  input  logic [DW-1:0]            alu_data,
  input  logic                     alu_float,
  output logic                     alu_ready,
  input  logic                     mdu_valid,
  input  logic [AW-1:0]            mdu_reg,
  input  logic [DW-1:0]            mdu_data,
  input  logic                     mdu_float,
  output logic                     mdu_ready,
  input  logic                     wb_hold,
  output logic [AW-1:0]            writeReg,
  output logic [DW-1:0]            writeData,
  output logic                     regWrite,
  output logic                     float,
  input  logic [AW-1:0]            fwdReg1,
  input  logic [AW-1:0]            fwdReg2,
  output logic                     fwdHit1,
  output logic                     fwdHit2,
  output logic [DW-1:0]            fwdData1,
  output logic [DW-1:0]            fwdData2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] reg_q  [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic          flt_q  [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;

  logic          nonempty, deq, space, acc, enq;
  logic          gnt_mem, gnt_alu, gnt_mdu;
  logic [AW-1:0] in_reg;
  logic [DW-1:0] in_data;
  logic          in_flt;
  logic [PW-1:0] idx;

  assign nonempty = (count_q != '0);
  assign deq      = nonempty & ~wb_hold;
  assign space    = (count_q < CW'(DEPTH)) | deq;

  assign gnt_mem = mem_valid;
  assign gnt_alu = alu_valid & ~mem_valid;
  assign gnt_mdu = mdu_valid & ~mem_valid & ~alu_valid;

  // readies are forced low while reset is held
  assign acc       = rst_n & space;
  assign mem_ready = acc & gnt_mem;
  assign alu_ready = acc & gnt_alu;
  assign mdu_ready = acc & gnt_mdu;

  always_comb begin
    in_reg  = mdu_reg;
    in_data = mdu_data;
    in_flt  = mdu_float;
    unique case (1'b1)
      gnt_mem: begin
        in_reg  = mem_reg;
        in_data = mem_data;
        in_flt  = mem_float;
      end
      gnt_alu: begin
        in_reg  = alu_reg;
        in_data = alu_data;
        in_flt  = alu_float;
      end
      default: ;
    endcase
  end

  // integer $0 results are acknowledged but dropped
  assign enq = acc & (gnt_mem | gnt_alu | gnt_mdu)
             & ((in_reg != '0) | in_flt);

  always_comb begin
    count_d = count_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
        flt_q[i]  <= 1'b0;
      end
    end else begin
      if (enq) begin
        reg_q[tail_q]  <= in_reg;
        data_q[tail_q] <= in_data;
        flt_q[tail_q]  <= in_flt;
        tail_q         <= tail_q + PW'(1);
      end
      if (deq) head_q <= head_q + PW'(1);
      count_q <= count_d;
    end
  end

  assign regWrite  = deq;
  assign writeReg  = nonempty ? reg_q[head_q]  : '0;
  assign writeData = nonempty ? data_q[head_q] : '0;
  assign float     = nonempty & flt_q[head_q];
  assign count     = count_q;

  // walk oldest to youngest so the last match wins
  always_comb begin
    fwdHit1  = 1'b0;
    fwdHit2  = 1'b0;
    fwdData1 = '0;
    fwdData2 = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && !flt_q[idx]) begin
        if ((fwdReg1 != '0) && (reg_q[idx] == fwdReg1)) begin
          fwdHit1  = 1'b1;
          fwdData1 = data_q[idx];
        end
        if ((fwdReg2 != '0) && (reg_q[idx] == fwdReg2)) begin
          fwdHit2  = 1'b1;
          fwdData2 = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: scoreboard of accepted results checked against
// drained writes, occupancy, arbitration and forwarding every cycle.
module tb_wb_write_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
    logic        f;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, alu_valid, mdu_valid;
  logic [4:0]  mem_reg, alu_reg, mdu_reg;
  logic [31:0] mem_data, alu_data, mdu_data;
  logic        mem_float, alu_float, mdu_float;
  logic        mem_ready, alu_ready, mdu_ready;
  logic        wb_hold;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        regWrite, float;
  logic [4:0]  fwdReg1, fwdReg2;
  logic        fwdHit1, fwdHit2;
  logic [31:0] fwdData1, fwdData2;
  logic [2:0]  count;

  int   errors = 0;
  int   checks = 0;
  ent_t sb[$];

  always #5 clk = ~clk;

  wb_write_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data),
    .mem_float(mem_float), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .alu_float(alu_float), .alu_ready(alu_ready),
    .mdu_valid(mdu_valid), .mdu_reg(mdu_reg), .mdu_data(mdu_data),
    .mdu_float(mdu_float), .mdu_ready(mdu_ready),
    .wb_hold(wb_hold),
    .writeReg(writeReg), .writeData(writeData),
    .regWrite(regWrite), .float(float),
    .fwdReg1(fwdReg1), .fwdReg2(fwdReg2),
    .fwdHit1(fwdHit1), .fwdHit2(fwdHit2),
    .fwdData1(fwdData1), .fwdData2(fwdData2),
    .count(count)
  );

  function automatic void model_fwd(input logic [4:0] r,
                                    output logic h,
                                    output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (r != 0)
      foreach (sb[i])
        if (!sb[i].f && sb[i].r == r) begin
          h = 1'b1;
          d = sb[i].d;
        end
  endfunction

  always @(negedge rst_n) sb.delete();

  logic        m_h1, m_h2, m_sp, m_rw;
  logic [31:0] m_d1, m_d2;
  logic [3:0]  m_ctl;
  ent_t        m_e;

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (count !== 3'(sb.size())) begin
        errors++;
        $display("FAIL occupancy: count=%0d want %0d", count, sb.size());
      end
      m_rw  = (sb.size() != 0) && !wb_hold;
      m_sp  = (sb.size() < DEPTH) || m_rw;
      m_ctl = {m_rw, mem_valid & m_sp,
               alu_valid & ~mem_valid & m_sp,
               mdu_valid & ~mem_valid & ~alu_valid & m_sp};
      checks++;
      if ({regWrite, mem_ready, alu_ready, mdu_ready} !== m_ctl) begin
        errors++;
        $display("FAIL arb: {wr,m,a,d}=%b want %b",
                 {regWrite, mem_ready, alu_ready, mdu_ready}, m_ctl);
      end
      model_fwd(fwdReg1, m_h1, m_d1);
      model_fwd(fwdReg2, m_h2, m_d2);
      checks++;
      if ({fwdHit1, fwdData1, fwdHit2, fwdData2} !== {m_h1, m_d1, m_h2, m_d2}) begin
        errors++;
        $display("FAIL fwd: got %b/%h %b/%h want %b/%h %b/%h",
                 fwdHit1, fwdData1, fwdHit2, fwdData2, m_h1, m_d1, m_h2, m_d2);
      end
      if (regWrite) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL write: unexpected reg=%0d data=%h", writeReg, writeData);
        end else begin
          m_e = sb.pop_front();
          if ({writeReg, writeData, float} !== m_e) begin
            errors++;
            $display("FAIL write: got r=%0d d=%h f=%b want r=%0d d=%h f=%b",
                     writeReg, writeData, float, m_e.r, m_e.d, m_e.f);
          end
        end
      end
      m_e = '0;
      if (mem_valid && mem_ready)      m_e = {mem_reg, mem_data, mem_float};
      else if (alu_valid && alu_ready) m_e = {alu_reg, alu_data, alu_float};
      else if (mdu_valid && mdu_ready) m_e = {mdu_reg, mdu_data, mdu_float};
      if ((mem_valid && mem_ready) || (alu_valid && alu_ready) ||
          (mdu_valid && mdu_ready))
        if (m_e.r != 0 || m_e.f) sb.push_back(m_e);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    for (int c = 0; c < 30 && count != 0; c++) @(negedge clk);
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL drain: count=%0d want 0", count);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    mem_valid = 1'b1; mem_reg = 5'd3; mem_data = 32'h1; mem_float = 1'b0;
    alu_valid = 1'b1; alu_reg = 5'd4; alu_data = 32'h2; alu_float = 1'b0;
    mdu_valid = 1'b1; mdu_reg = 5'd6; mdu_data = 32'h3; mdu_float = 1'b0;
    wb_hold = 1'b0; fwdReg1 = 5'd3; fwdReg2 = 5'd4;
    #13;
    checks++;
    if ({mem_ready, alu_ready, mdu_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready: %b want 000", {mem_ready, alu_ready, mdu_ready});
    end
    checks++;
    if ({count, regWrite, float} !== 5'd0) begin
      errors++;
      $display("FAIL reset_ctl: count=%0d wr=%b f=%b want 0", count, regWrite, float);
    end
    checks++;
    if ({writeReg, writeData} !== 37'd0) begin
      errors++;
      $display("FAIL reset_head: r=%0d d=%h want 0", writeReg, writeData);
    end
    checks++;
    if ({fwdHit1, fwdHit2, fwdData1, fwdData2} !== 66'd0) begin
      errors++;
      $display("FAIL reset_fwd: hits=%b%b want 00", fwdHit1, fwdHit2);
    end
    mem_valid = 1'b0; alu_valid = 1'b0; mdu_valid = 1'b0;
    fwdReg1 = 5'd0; fwdReg2 = 5'd0;
    #4 rst_n = 1'b1;
  endtask

  task automatic test_single;
    tick;
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF; alu_float = 1'b0;
    @(negedge clk);
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: %b want 1", alu_ready);
    end
    tick;
    alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({regWrite, writeReg, writeData, float} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL single_write: wr=%b r=%0d d=%h f=%b want 1/5/deadbeef/0",
               regWrite, writeReg, writeData, float);
    end
    @(negedge clk);
    checks++;
    if ({regWrite, count} !== 4'd0) begin
      errors++;
      $display("FAIL single_after: wr=%b count=%0d want 0/0", regWrite, count);
    end
  endtask

  task automatic test_priority;
    tick;
    mem_valid = 1'b1; mem_reg = 5'd1; mem_data = 32'h11; mem_float = 1'b0;
    alu_valid = 1'b1; alu_reg = 5'd2; alu_data = 32'h22; alu_float = 1'b0;
    mdu_valid = 1'b1; mdu_reg = 5'd3; mdu_data = 32'h33; mdu_float = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_ready, alu_ready, mdu_ready} !== 3'b100) begin
      errors++;
      $display("FAIL prio_c0: %b want 100", {mem_ready, alu_ready, mdu_ready});
    end
    tick;
    mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({alu_ready, mdu_ready} !== 2'b10) begin
      errors++;
      $display("FAIL prio_c1: %b want 10", {alu_ready, mdu_ready});
    end
    tick;
    alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mdu_ready !== 1'b1) begin
      errors++;
      $display("FAIL prio_c2: mdu_ready=%b want 1", mdu_ready);
    end
    tick;
    mdu_valid = 1'b0;
    drain();
  endtask

  task automatic test_full;
    int n;
    wb_hold = 1'b1;
    for (int r = 1; r <= 6; r++) begin
      tick;
      if (r == 1) wb_hold = 1'b1;
      alu_valid = 1'b1; alu_reg = 5'(r); alu_data = 32'hA000_0000 + r;
      alu_float = 1'b0;
      n = 0;
      @(negedge clk);
      while (!alu_ready && n < 20) begin
        if (n == 2) begin
          checks++;
          if ({count, alu_ready} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL full: count=%0d ready=%b want 4/0", count, alu_ready);
          end
        end
        tick;
        if (n == 2) wb_hold = 1'b0;
        @(negedge clk);
        n++;
      end
      checks++;
      if (alu_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_accept: reg %0d ready=%b want 1", r, alu_ready);
      end
    end
    tick;
    alu_valid = 1'b0;
    drain();
  endtask

  task automatic test_zero;
    tick;
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'h1234; alu_float = 1'b0;
    @(negedge clk);
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_ready: %b want 1", alu_ready);
    end
    tick;
    alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({count, regWrite} !== 4'd0) begin
      errors++;
      $display("FAIL zero_drop: count=%0d wr=%b want 0/0", count, regWrite);
    end
    tick;
    alu_valid = 1'b1; alu_float = 1'b1;
    tick;
    alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({regWrite, writeReg, writeData, float} !== {1'b1, 5'd0, 32'h1234, 1'b1}) begin
      errors++;
      $display("FAIL zero_float: wr=%b r=%0d d=%h f=%b want 1/0/1234/1",
               regWrite, writeReg, writeData, float);
    end
    alu_float = 1'b0;
    drain();
  endtask

  task automatic test_fwd;
    tick;
    wb_hold = 1'b1;
    alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'hAAAA_0001; alu_float = 1'b0;
    tick;
    alu_data = 32'hBBBB_0002;
    tick;
    alu_reg = 5'd9; alu_data = 32'hCCCC_0003; alu_float = 1'b1;
    tick;
    alu_valid = 1'b0; alu_float = 1'b0;
    fwdReg1 = 5'd7; fwdReg2 = 5'd0;
    @(negedge clk);
    checks++;
    if ({fwdHit1, fwdData1, fwdHit2, fwdData2} !== {1'b1, 32'hBBBB_0002, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL fwd_young: h1=%b d1=%h h2=%b want 1/bbbb0002/0",
               fwdHit1, fwdData1, fwdHit2);
    end
    tick;
    fwdReg2 = 5'd9;
    @(negedge clk);
    checks++;
    if (fwdHit2 !== 1'b0) begin
      errors++;
      $display("FAIL fwd_float: h2=%b want 0", fwdHit2);
    end
    tick;
    wb_hold = 1'b0;
    drain();
    fwdReg1 = 5'd0; fwdReg2 = 5'd0;
  endtask

  task automatic test_reset_mid;
    tick;
    wb_hold = 1'b1;
    alu_valid = 1'b1; alu_float = 1'b0;
    for (int r = 10; r < 13; r++) begin
      alu_reg = 5'(r); alu_data = 32'h5000 + r;
      tick;
    end
    alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL rmid_fill: count=%0d want 3", count);
    end
    tick;
    #2;
    wb_hold = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({count, regWrite} !== 4'd0) begin
      errors++;
      $display("FAIL rmid_async: count=%0d wr=%b want 0/0", count, regWrite);
    end
    #2 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (regWrite !== 1'b0) begin
        errors++;
        $display("FAIL rmid_stale: wr=%b r=%0d want 0", regWrite, writeReg);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit am, aa, ad;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      am = mem_valid && mem_ready;
      aa = alu_valid && alu_ready;
      ad = mdu_valid && mdu_ready;
      tick;
      if (!mem_valid || am) begin
        mem_valid = 1'($urandom_range(0, 1));
        mem_reg = 5'($urandom_range(0, 7));
        mem_data = $urandom;
        mem_float = ($urandom_range(0, 3) == 0);
      end
      if (!alu_valid || aa) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_reg = 5'($urandom_range(0, 7));
        alu_data = $urandom;
        alu_float = ($urandom_range(0, 3) == 0);
      end
      if (!mdu_valid || ad) begin
        mdu_valid = 1'($urandom_range(0, 1));
        mdu_reg = 5'($urandom_range(0, 7));
        mdu_data = $urandom;
        mdu_float = ($urandom_range(0, 3) == 0);
      end
      wb_hold = ($urandom_range(0, 3) == 0);
      fwdReg1 = 5'($urandom_range(0, 7));
      fwdReg2 = 5'($urandom_range(0, 7));
    end
    @(negedge clk);
    tick;
    mem_valid = 1'b0; alu_valid = 1'b0; mdu_valid = 1'b0;
    wb_hold = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_full();
    test_zero();
    test_fwd();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Producer side of the 32x32 register file write port: arbitrates writeback results from the memory stage, the integer ALU and the multiply/divide unit.
- Buffers accepted results in a small FIFO and drains at most one entry per cycle onto the register file's writeReg/writeData/regWrite/float inputs.
- Also answers two forwarding lookups for operands still sitting in the queue, so decode reads never miss a result that is accepted but not yet written.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_valid  input  1  memory-stage result valid.
- mem_reg  input  AW  destination register.
- mem_data  input  DW  result data.
- mem_float  input  1  destination is the float file.
- mem_ready  output  1  mem result accepted this cycle.
- alu_valid, alu_reg, alu_data, alu_float, alu_ready  same widths and meanings, ALU source.
- mdu_valid, mdu_reg, mdu_data, mdu_float, mdu_ready  same widths and meanings, mul/div source.
- wb_hold  input  1  register file cannot take a write this cycle; head is not dequeued.
- writeReg  output  AW  register file write address.
- writeData  output  DW  register file write data.
- regWrite  output  1  write strobe, high while head entry is valid and wb_hold low.
- float  output  1  float flag of head entry.
- fwdReg1, fwdReg2  input  AW  forwarding lookup addresses (decode readReg1/readReg2).
- fwdHit1, fwdHit2  output  1  a queued entry targets the looked-up register.
- fwdData1, fwdData2  output  DW  data of the youngest matching entry.
- count  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty, count=0, regWrite=0, writeReg=0, writeData=0, float=0.
  - All ready outputs 0 while reset is asserted; fwdHit1/2=0, fwdData1/2=0.
  - Reset mid-operation discards all queued entries; no write issues after deassertion until a new accept.
- Arbitration:
  - Fixed priority mem > alu > mdu.
  - At most one source granted per cycle: X_ready=1 only for the highest-priority valid source, and only if the FIFO has space (count<DEPTH, or count==DEPTH with a dequeue this cycle).
  - Losing sources see ready=0 and must hold valid/reg/data/float stable.
- Accept (valid & ready at rising edge):
  - Entry {reg,data,float} enqueued at tail.
  - If reg==0 and float==0, the result is accepted but not enqueued: ready still 1, count unchanged. Integer register $0 is never written.
  - Float register 0 is enqueued normally.
- Drain:
  - Head presented combinationally on writeReg/writeData/float.
  - regWrite = (count!=0) & ~wb_hold.
  - Dequeue on a rising edge when regWrite=1.
  - Latency: a result accepted at edge N into an empty queue drives regWrite during cycle N+1 and is written at edge N+1. No same-cycle bypass from input to output.
- Simultaneous enqueue and dequeue:
  - Allowed at any occupancy, including full; count unchanged.
  - Pointers wrap modulo DEPTH.
- Forwarding:
  - Combinational search of all valid entries for reg==fwdRegK with float==0.
  - Youngest match (closest to tail) wins.
  - fwdRegK==0 always gives hit=0, data=0.
  - An entry being dequeued this cycle still counts as a hit. The register file captures it on the same edge.
  - A same-cycle incoming source is not searched.
- Empty with wb_hold high: no effect.
- Full with no dequeue: all ready=0.

Test Plan:
- Reset then alu_valid=1, alu_reg=5, alu_data=32'hDEADBEEF -> alu_ready=1; next cycle regWrite=1, writeReg=5, writeData=DEADBEEF, float=0; following cycle regWrite=0, count=0.
- mem, alu, mdu all valid same cycle (regs 1,2,3), wb_hold=0 -> accept order mem, alu, mdu on consecutive cycles; writes to regs 1,2,3 in that order; alu_ready low for 1 cycle, mdu_ready low for 2.
- wb_hold=1 with alu streaming regs 1..6 -> count reaches 4, alu_ready=0; release wb_hold -> writes drain in order 1..6, never more than 4 queued.
- alu_reg=0, float=0, data=32'h1234 -> alu_ready=1, count stays 0, regWrite never asserts; same with float=1 -> enqueued, float=1 on output.
- Queue holds reg7=A (older), reg7=B (younger), wb_hold=1, fwdReg1=7, fwdReg2=0 -> fwdHit1=1, fwdData1=B, fwdHit2=0.
- Queue holds 3 entries, pulse rst_n low mid-cycle -> regWrite and count drop to 0 immediately (asynchronously); after release, no stale write appears.
